// File: rtl/extensor_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : extensor_param_if
//  Description : Handshake bundle for the immediate extender. The producer
//                side offers entrada/modo and the consumer side takes saida.
//                The master modport is the environment, the slave modport is
//                the extender.
//  Revision    : 1.0 - initial release
// ============================================================================
interface extensor_param_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8
);

    logic [IN_W-1:0]  entrada;
    logic [1:0]       modo;
    logic             entrada_valida;
    logic             entrada_pronta;
    logic [OUT_W-1:0] saida;
    logic             saida_valida;
    logic             saida_pronta;
    logic [7:0]       contador;

    // Environment: drives the input side and the consumer ready.
    modport master (
        output entrada,
        output modo,
        output entrada_valida,
        output saida_pronta,
        input  entrada_pronta,
        input  saida,
        input  saida_valida,
        input  contador
    );

    // Extender: consumes the input side and drives the result side.
    modport slave (
        input  entrada,
        input  modo,
        input  entrada_valida,
        input  saida_pronta,
        output entrada_pronta,
        output saida,
        output saida_valida,
        output contador
    );

endinterface
`default_nettype wire

// File: rtl/extensor_param.sv
`default_nettype none
// ============================================================================
//  Module      : extensor_param
//  Description : Parameterised immediate extender (zero/sign extend, with an
//                optional left shift) behind a 2-entry skid buffer. The
//                extension is captured at the input transfer edge, results
//                leave in acceptance order, and contador counts completed
//                output transfers (wrapping at 256).
//  Revision    : 1.0 - initial release
// ============================================================================
module extensor_param #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8,
    parameter int SHIFT = 1
) (
    input  wire logic         clock,
    input  wire logic         reset,   // asynchronous, active-low
    extensor_param_if.slave   bus
);

    // Buffer occupancy: nothing held, one result held, both registers held.
    typedef enum logic [1:0] {
        VAZIO = 2'd0,
        UM    = 2'd1,
        CHEIO = 2'd2
    } estado_t;

    localparam logic [7:0] c_CNT_ONE = 8'd1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    estado_t          r_estado;
    logic [OUT_W-1:0] r_principal;   // drives saida
    logic [OUT_W-1:0] r_skid;        // second entry, only used when CHEIO
    logic             r_pronta;
    logic             r_valida;
    logic [7:0]       r_contador;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_base;
    logic [OUT_W-1:0] w_ext;
    logic             w_in_xfer;
    logic             w_out_xfer;
    estado_t          w_estado_prox;
    logic             w_carrega_principal;
    logic             w_principal_do_skid;
    logic             w_carrega_skid;

    // Both handshakes are qualified only by registered ready/valid, so there
    // is no combinational path from saida_pronta to entrada_pronta.
    assign w_in_xfer  = bus.entrada_valida & r_pronta;
    assign w_out_xfer = r_valida & bus.saida_pronta;

    // Extension of the current input: bit 0 of modo picks sign vs zero fill,
    // bit 1 applies the left shift (bits above OUT_W-1 are dropped).
    always_comb begin
        w_zext = OUT_W'(bus.entrada);
        w_sext = OUT_W'($signed(bus.entrada));
        w_base = bus.modo[0] ? w_sext : w_zext;
        w_ext  = bus.modo[1] ? (w_base << SHIFT) : w_base;
    end

    // Next-state and data-path steering for the skid buffer.
    always_comb begin
        w_estado_prox       = r_estado;
        w_carrega_principal = 1'b0;
        w_principal_do_skid = 1'b0;
        w_carrega_skid      = 1'b0;
        case (r_estado)
            VAZIO: begin
                if (w_in_xfer) begin
                    w_estado_prox       = UM;
                    w_carrega_principal = 1'b1;
                end
            end
            UM: begin
                case ({w_in_xfer, w_out_xfer})
                    2'b10: begin
                        // Consumer stalled: park the new result behind saida.
                        w_estado_prox  = CHEIO;
                        w_carrega_skid = 1'b1;
                    end
                    2'b01: begin
                        w_estado_prox = VAZIO;
                    end
                    2'b11: begin
                        // Pass-through: replace the departing result directly.
                        w_estado_prox       = UM;
                        w_carrega_principal = 1'b1;
                    end
                    default: begin
                        w_estado_prox = UM;
                    end
                endcase
            end
            CHEIO: begin
                // No input can be accepted here (entrada_pronta is low), so
                // an output simply promotes the skid entry.
                if (w_out_xfer) begin
                    w_estado_prox       = UM;
                    w_carrega_principal = 1'b1;
                    w_principal_do_skid = 1'b1;
                end
            end
            default: begin
                w_estado_prox = VAZIO;
            end
        endcase
    end

    // State register plus registered ready/valid derived from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= VAZIO;
            r_pronta <= 1'b1;
            r_valida <= 1'b0;
        end else begin
            r_estado <= w_estado_prox;
            r_pronta <= (w_estado_prox != CHEIO);
            r_valida <= (w_estado_prox != VAZIO);
        end
    end

    // Result storage: main register and skid register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_principal <= '0;
            r_skid      <= '0;
        end else begin
            if (w_carrega_principal) begin
                r_principal <= w_principal_do_skid ? r_skid : w_ext;
            end
            if (w_carrega_skid) begin
                r_skid <= w_ext;
            end
        end
    end

    // Completed output transfer counter, wraps naturally at 8 bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_contador <= '0;
        end else if (w_out_xfer) begin
            r_contador <= r_contador + c_CNT_ONE;
        end
    end

    assign bus.entrada_pronta = r_pronta;
    assign bus.saida_valida   = r_valida;
    assign bus.saida          = r_principal;
    assign bus.contador       = r_contador;

endmodule
`default_nettype wire
